// File: rtl/output_buffer_pkg.sv
// Shared types and sizing for the FIR output buffer.
package output_buffer_pkg;

    localparam int unsigned DATA_W       = 32;
    localparam int unsigned DEPTH        = 16;
    localparam int unsigned PTR_W        = 4;
    localparam int unsigned START_THRESH = 8;
    localparam int unsigned IDLE_TIMEOUT = 16;
    localparam int unsigned IDLE_W       = 5;
    localparam int unsigned BUS_W        = DATA_W + 1;

    // Sample bus: valid-qualified 32-bit word, valid in the MSB.
    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data;
    } data_bus_t;

    localparam logic OB_FILL   = 1'b0;
    localparam logic OB_STREAM = 1'b1;

endpackage

// File: rtl/output_buffer.sv
// Elastic output FIFO for the FIR core: pre-fills to a threshold, then streams
// under valid/ready; a short tail is flushed once input stays idle long enough.
module output_buffer
    import output_buffer_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BUS_W-1:0] data_in,
    input  logic             out_ready,
    input  logic             clear_ovf,
    output logic [BUS_W-1:0] data_out,
    output logic [PTR_W:0]   level,
    output logic             overflow
);

    data_bus_t         din;
    data_bus_t         dout;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    level_q, level_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              state_q, state_d;
    logic              ovf_q, ovf_d;
    logic              pop, push, drop;

    assign din      = data_in;
    assign data_out = dout;
    assign level    = level_q;
    assign overflow = ovf_q;

    // Head of queue is presented combinationally; valid only while streaming.
    always_comb begin
        dout.valid = (state_q == OB_STREAM) && (level_q != '0);
        dout.data  = mem_q[rd_ptr_q];
    end

    // A full buffer still accepts a sample when the head leaves in the same cycle.
    always_comb begin
        pop      = dout.valid & out_ready;
        push     = din.valid & ((level_q != (PTR_W+1)'(DEPTH)) | pop);
        drop     = din.valid & ~push;
        level_d  = level_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        ovf_d    = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clear_ovf) begin
            ovf_d = 1'b0;
        end
    end

    // Fill/stream control, evaluated on the post-update occupancy.
    always_comb begin
        state_d = state_q;
        idle_d  = idle_q;
        case (state_q)
            OB_FILL: begin
                if (din.valid) begin
                    idle_d = '0;
                end else if (idle_q != IDLE_W'(IDLE_TIMEOUT)) begin
                    idle_d = idle_q + IDLE_W'(1);
                end
                if ((level_d >= (PTR_W+1)'(START_THRESH)) ||
                    ((idle_d >= IDLE_W'(IDLE_TIMEOUT)) && (level_d != '0))) begin
                    state_d = OB_STREAM;
                end
            end
            OB_STREAM: begin
                if (level_d == '0) begin
                    state_d = OB_FILL;
                    idle_d  = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            idle_q   <= '0;
            state_q  <= OB_FILL;
            ovf_q    <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            idle_q   <= idle_d;
            state_q  <= state_d;
            ovf_q    <= ovf_d;
            if (push) begin
                mem_q[wr_ptr_q] <= din.data;
            end
        end
    end

endmodule
